// File: rtl/pmu_event_selector.sv
// Purpose: per-channel raw-signal mux + level/edge detection feeding PMU events_i.
// Latency: raw_i -> events_o 2 cycles; config read-back 1 cycle.
// Backpressure: none; every input is consumed each cycle. Optional lock: PMU_EVSEL_LOCK_EN.
module pmu_event_selector #(
  parameter int N_RAW    = 64,
  parameter int N_EVENTS = 16,
  parameter int SEL_W    = $clog2(N_RAW),
  parameter int IDX_W    = $clog2(N_EVENTS) + 1,
  parameter int CFG_W    = SEL_W + 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_RAW-1:0]    raw_i,
  input  logic                cfg_we_i,
  input  logic [IDX_W-1:0]    cfg_idx_i,
  input  logic [CFG_W-1:0]    cfg_wdata_i,
  output logic [CFG_W-1:0]    cfg_rdata_o,
  output logic [N_EVENTS-1:0] events_o
);

  // Selector space rounded up to a power of two; the padding reads as 0
  localparam int                 RAW_PAD  = 1 << SEL_W;
  localparam logic [IDX_W-1:0]   LOCK_IDX = '1;
  localparam logic [IDX_W-1:0]   NUM_CH   = IDX_W'(N_EVENTS);

  logic [N_RAW-1:0]    r_raw_q;
  logic [RAW_PAD-1:0]  w_raw_pad;
  logic [CFG_W-1:0]    r_cfg [N_EVENTS];
  logic [N_EVENTS-1:0] r_hist;
  logic [N_EVENTS-1:0] r_hv;
  logic [N_EVENTS-1:0] r_events;
  logic [CFG_W-1:0]    r_rdata;
  logic                r_run;
  logic [N_EVENTS-1:0] w_en;
  logic [N_EVENTS-1:0] w_sample;
  logic [N_EVENTS-1:0] w_det;
  logic [N_EVENTS-1:0] w_wr_ch;
  logic [CFG_W-1:0]    w_rdata;
  logic [IDX_W-2:0]    w_ch_idx;
  logic                w_idx_ch;
  logic                w_locked;
  logic                w_wr_ok;

  generate
    if (RAW_PAD > N_RAW) begin : g_pad
      assign w_raw_pad = {{(RAW_PAD-N_RAW){1'b0}}, r_raw_q};
    end else begin : g_nopad
      assign w_raw_pad = r_raw_q;
    end
  endgenerate

  // Write decode: only real channels, and only while not locked
  assign w_idx_ch = (cfg_idx_i < NUM_CH);
  assign w_ch_idx = cfg_idx_i[IDX_W-2:0];
  assign w_wr_ok  = cfg_we_i & w_idx_ch & ~w_locked;

`ifdef PMU_EVSEL_LOCK_EN
  logic r_lock;

  // Sticky lock bit; only reset clears it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock <= 1'b0;
    end else if (cfg_we_i && (cfg_idx_i == LOCK_IDX) && cfg_wdata_i[0]) begin
      r_lock <= 1'b1;
    end
  end

  assign w_locked = r_lock;
`else
  assign w_locked = 1'b0;
`endif

  // One-hot of the channel being rewritten this cycle
  always_comb begin
    w_wr_ch = '0;
    if (w_wr_ok) begin
      w_wr_ch[w_ch_idx] = 1'b1;
    end
  end

  // Per-channel sample selection and mode evaluation
  always_comb begin
    w_en     = '0;
    w_sample = '0;
    w_det    = '0;
    for (int c = 0; c < N_EVENTS; c++) begin
      w_en[c]     = r_cfg[c][CFG_W-1];
      w_sample[c] = w_raw_pad[r_cfg[c][SEL_W-1:0]];
      case (r_cfg[c][SEL_W +: 2])
        2'b00:   w_det[c] = w_sample[c];
        2'b01:   w_det[c] = r_hv[c] & w_sample[c] & ~r_hist[c];
        2'b10:   w_det[c] = r_hv[c] & ~w_sample[c] & r_hist[c];
        default: w_det[c] = r_hv[c] & (w_sample[c] ^ r_hist[c]);
      endcase
    end
  end

  // Read-back mux; reserved indices return 0
  always_comb begin
    w_rdata = '0;
    if (w_idx_ch) begin
      w_rdata = r_cfg[w_ch_idx];
    end
`ifdef PMU_EVSEL_LOCK_EN
    else if (cfg_idx_i == LOCK_IDX) begin
      w_rdata = {{(CFG_W-1){1'b0}}, r_lock};
    end
`endif
  end

  // Input capture and detection pipeline. A channel write drops its
  // history-valid flag so a sel change cannot fake an edge; r_run keeps
  // the first post-reset sample from counting as valid history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_raw_q  <= '0;
      r_run    <= 1'b0;
      r_hist   <= '0;
      r_hv     <= '0;
      r_events <= '0;
    end else begin
      r_raw_q  <= raw_i;
      r_run    <= 1'b1;
      r_hist   <= w_sample;
      r_hv     <= {N_EVENTS{r_run}} & ~w_wr_ch;
      r_events <= w_en & w_det & ~w_wr_ch;
    end
  end

  // Channel configuration registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < N_EVENTS; c++) begin
        r_cfg[c] <= '0;
      end
    end else if (w_wr_ok) begin
      r_cfg[w_ch_idx] <= cfg_wdata_i;
    end
  end

  // Registered read-back; same-cycle write shows the old value
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign events_o    = r_events;
  assign cfg_rdata_o = r_rdata;

endmodule

// File: tb/tb_pmu_event_selector.sv
// Directed vector bench for pmu_event_selector (default parameters).
// Each vector: inputs applied, one clock, outputs compared 1 time unit later.
// Lock expectations follow whether PMU_EVSEL_LOCK_EN is defined.
module tb_pmu_event_selector;

`ifdef PMU_EVSEL_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [63:0] raw_i = '0;
  logic        cfg_we_i = 1'b0;
  logic [4:0]  cfg_idx_i = '0;
  logic [8:0]  cfg_wdata_i = '0;
  logic [8:0]  cfg_rdata_o;
  logic [15:0] events_o;

  int total = 0;
  int bad   = 0;

  pmu_event_selector dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .raw_i       (raw_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_idx_i   (cfg_idx_i),
    .cfg_wdata_i (cfg_wdata_i),
    .cfg_rdata_o (cfg_rdata_o),
    .events_o    (events_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] raw;
    logic        we;
    logic [4:0]  idx;
    logic [8:0]  wd;
    logic [15:0] ev;
    logic [8:0]  rd;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl [NV];

  function automatic vec_t v(input logic [63:0] raw, input logic we, input logic [4:0] idx,
                             input logic [8:0] wd, input logic [15:0] ev, input logic [8:0] rd);
    vec_t r;
    r.raw = raw; r.we = we; r.idx = idx; r.wd = wd; r.ev = ev; r.rd = rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [63:0] raw, input logic we, input logic [4:0] idx,
                       input logic [8:0] wd);
    raw_i = raw; cfg_we_i = we; cfg_idx_i = idx; cfg_wdata_i = wd;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // cfg words {en, mode[1:0], sel[5:0]}
    // ch0 level sel5 = 105, ch1 rise sel7 = 147, ch2 any sel7 = 1C7,
    // ch3 rise sel9 = 149, ch3 rise sel10 = 14A
    tbl[0]  = v(64'h0,   1, 0,  9'h105, 16'h0000, 9'h000);
    tbl[1]  = v(64'h0,   0, 0,  9'h000, 16'h0000, 9'h105);
    tbl[2]  = v(64'h20,  0, 0,  9'h000, 16'h0000, 9'h105);
    tbl[3]  = v(64'h20,  0, 0,  9'h000, 16'h0001, 9'h105);
    tbl[4]  = v(64'h20,  0, 0,  9'h000, 16'h0001, 9'h105);
    tbl[5]  = v(64'h20,  0, 0,  9'h000, 16'h0001, 9'h105);
    tbl[6]  = v(64'h0,   0, 0,  9'h000, 16'h0001, 9'h105);
    tbl[7]  = v(64'h0,   0, 0,  9'h000, 16'h0000, 9'h105);
    tbl[8]  = v(64'h0,   1, 1,  9'h147, 16'h0000, 9'h000);
    tbl[9]  = v(64'h0,   1, 2,  9'h1C7, 16'h0000, 9'h000);
    tbl[10] = v(64'h0,   0, 1,  9'h000, 16'h0000, 9'h147);
    tbl[11] = v(64'h80,  0, 1,  9'h000, 16'h0000, 9'h147);
    tbl[12] = v(64'h80,  0, 2,  9'h000, 16'h0006, 9'h1C7);
    tbl[13] = v(64'h0,   0, 2,  9'h000, 16'h0000, 9'h1C7);
    tbl[14] = v(64'h0,   0, 2,  9'h000, 16'h0004, 9'h1C7);
    tbl[15] = v(64'h0,   0, 2,  9'h000, 16'h0000, 9'h1C7);
    tbl[16] = v(64'h400, 1, 3,  9'h149, 16'h0000, 9'h000);
    tbl[17] = v(64'h400, 0, 3,  9'h000, 16'h0000, 9'h149);
    tbl[18] = v(64'h400, 0, 3,  9'h000, 16'h0000, 9'h149);
    tbl[19] = v(64'h400, 1, 3,  9'h14A, 16'h0000, 9'h149);
    tbl[20] = v(64'h400, 0, 3,  9'h000, 16'h0000, 9'h14A);
    tbl[21] = v(64'h0,   0, 3,  9'h000, 16'h0000, 9'h14A);
    tbl[22] = v(64'h400, 0, 3,  9'h000, 16'h0000, 9'h14A);
    tbl[23] = v(64'h400, 0, 3,  9'h000, 16'h0008, 9'h14A);
    tbl[24] = v(64'h400, 0, 3,  9'h000, 16'h0000, 9'h14A);
    tbl[25] = v(64'h0,   0, 3,  9'h000, 16'h0000, 9'h14A);
    tbl[26] = v(64'h400, 0, 3,  9'h000, 16'h0000, 9'h14A);
    tbl[27] = v(64'h400, 1, 3,  9'h14A, 16'h0000, 9'h14A);
    tbl[28] = v(64'h400, 0, 3,  9'h000, 16'h0000, 9'h14A);
    tbl[29] = v(64'h20,  0, 3,  9'h000, 16'h0000, 9'h14A);
    tbl[30] = v(64'h20,  1, 1,  9'h147, 16'h0001, 9'h147);
    tbl[31] = v(64'h0,   0, 1,  9'h000, 16'h0001, 9'h147);
    tbl[32] = v(64'h0,   0, 1,  9'h000, 16'h0000, 9'h147);
    tbl[33] = v(64'h0,   1, 20, 9'h1FF, 16'h0000, 9'h000);
    tbl[34] = v(64'h0,   0, 20, 9'h000, 16'h0000, 9'h000);

    // Reset held with toggling raw input
    repeat (3) begin
      @(posedge clk_i);
      #1 raw_i = ~raw_i;
    end
    chk("reset_events", {16'h0, events_o}, 32'h0);
    chk("reset_rdata", {23'h0, cfg_rdata_o}, 32'h0);
    raw_i = '0;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].raw, tbl[i].we, tbl[i].idx, tbl[i].wd);
      chk($sformatf("vec%0d_events", i), {16'h0, events_o}, {16'h0, tbl[i].ev});
      chk($sformatf("vec%0d_rdata", i), {23'h0, cfg_rdata_o}, {23'h0, tbl[i].rd});
    end

    // Lock register
    apply(64'h0, 1, 31, 9'h001);
    chk("lock_wr_rd_old", {23'h0, cfg_rdata_o}, 32'h0);
    apply(64'h0, 0, 31, 9'h000);
    chk("lock_rd", {23'h0, cfg_rdata_o}, LOCK ? 32'h1 : 32'h0);
    apply(64'h0, 1, 0, 9'h000);
    chk("lock_ch0_wr_rd_old", {23'h0, cfg_rdata_o}, 32'h105);
    apply(64'h20, 0, 0, 9'h000);
    chk("lock_ch0_rd", {23'h0, cfg_rdata_o}, LOCK ? 32'h105 : 32'h0);
    apply(64'h20, 0, 0, 9'h000);
    chk("lock_ch0_events", {16'h0, events_o}, LOCK ? 32'h1 : 32'h0);

    // Re-enable ch0 (no-op when locked), then reset mid-stream
    apply(64'h20, 1, 0, 9'h105);
    apply(64'h20, 0, 0, 9'h000);
    chk("pre_rst_events", {16'h0, events_o}, 32'h1);
    chk("pre_rst_rdata", {23'h0, cfg_rdata_o}, 32'h105);
    #2 rst_i = 1'b1;
    raw_i = ~raw_i;
    #1;
    chk("async_rst_events", {16'h0, events_o}, 32'h0);
    chk("async_rst_rdata", {23'h0, cfg_rdata_o}, 32'h0);
    repeat (2) begin
      @(posedge clk_i);
      #1 raw_i = ~raw_i;
    end
    rst_i = 1'b0;
    apply(64'h20, 0, 3, 9'h000);
    chk("post_rst_idx3", {23'h0, cfg_rdata_o}, 32'h0);
    apply(64'h20, 0, 31, 9'h000);
    chk("post_rst_idx31", {23'h0, cfg_rdata_o}, 32'h0);
    apply(64'h20, 0, 0, 9'h000);
    chk("post_rst_ch0", {23'h0, cfg_rdata_o}, 32'h0);
    chk("post_rst_events", {16'h0, events_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
